// File: rtl/cpuc_package.sv
// Shared constants and state type for the CPU-C register bank.
package cpuc_package;

    localparam int NUM_OF_REGS     = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int NUM_OF_WR_PORTS = 2;
    localparam int NUM_OF_RD_PORTS = 2;

    typedef enum logic {
        IDLE = 1'b0,
        INIT = 1'b1
    } t_reg_bank_state;

endpackage

// File: rtl/cpuc_reg_bank_if.sv
// Write/read port bundle of the register bank.
interface cpuc_reg_bank_if #(
    parameter int NUM_WR_PORTS = cpuc_package::NUM_OF_WR_PORTS,
    parameter int NUM_RD_PORTS = cpuc_package::NUM_OF_RD_PORTS,
    parameter int AW           = $clog2(cpuc_package::NUM_OF_REGS),
    parameter int DATA_WIDTH   = cpuc_package::DATA_WIDTH
);

    logic [NUM_WR_PORTS-1:0]                 wr_en;
    logic [NUM_WR_PORTS-1:0][AW-1:0]         wr_addr;
    logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data;
    logic [NUM_RD_PORTS-1:0][AW-1:0]         rd_addr;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/cpuc_reg_bank_wr_arb.sv
// Resolves the write ports into one per-register write, highest port wins.
module cpuc_reg_bank_wr_arb #(
    parameter int NUM_REGS     = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WR_PORTS = 2,
    parameter int AW           = 5
) (
    input  logic                                 accept,
    input  logic [NUM_WR_PORTS-1:0]              wr_en,
    input  logic [NUM_WR_PORTS-1:0][AW-1:0]      wr_addr,
    input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data,
    output logic [NUM_REGS-1:0]                  reg_we,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  reg_wdata,
    output logic                                 collision,
    output logic                                 dropped
);

    logic [NUM_WR_PORTS-1:0] valid;

    always_comb begin
        valid     = '0;
        reg_we    = '0;
        reg_wdata = '0;
        collision = 1'b0;
        dropped   = 1'b0;

        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (wr_en[p]) begin
                if (accept && (32'(wr_addr[p]) < NUM_REGS)) begin
                    valid[p] = 1'b1;
                end else begin
                    dropped = 1'b1;
                end
            end
        end

        // Ascending scan: a later port overwrites an earlier one.
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            if (valid[p]) begin
                reg_we[wr_addr[p]]    = 1'b1;
                reg_wdata[wr_addr[p]] = wr_data[p];
            end
        end

        for (int p = 0; p < NUM_WR_PORTS; p++) begin
            for (int q = p + 1; q < NUM_WR_PORTS; q++) begin
                if (valid[p] && valid[q] && (wr_addr[p] == wr_addr[q])) begin
                    collision = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cpuc_reg_bank.sv
// Multi-port register bank with sequential clear and a shadow snapshot.
module cpuc_reg_bank #(
    parameter int NUM_REGS     = cpuc_package::NUM_OF_REGS,
    parameter int DATA_WIDTH   = cpuc_package::DATA_WIDTH,
    parameter int NUM_WR_PORTS = cpuc_package::NUM_OF_WR_PORTS,
    parameter int NUM_RD_PORTS = cpuc_package::NUM_OF_RD_PORTS
) (
    input  logic                           clk,
    input  logic                           rst,
    cpuc_reg_bank_if.slave                 bus,
    input  logic                           init_req,
    output logic                           init_busy,
    output logic                           init_done,
    input  logic                           snap_req,
    input  logic                           restore_req,
    output logic                           wr_collision,
    output logic                           wr_dropped,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_outputs
);

    import cpuc_package::*;

    localparam int            AW       = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    t_reg_bank_state state_q;
    logic [AW-1:0]   cnt_q;
    logic            init_busy_q;
    logic            init_done_q;

    logic [DATA_WIDTH-1:0] regs_q   [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d   [NUM_REGS];
    logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] shadow_d [NUM_REGS];

    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data_d;

    logic wr_collision_q;
    logic wr_collision_d;
    logic wr_dropped_q;
    logic wr_dropped_d;

    logic                                idle;
    logic                                accept;
    logic [NUM_REGS-1:0]                 reg_we;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] reg_wdata;

    assign idle   = (state_q == IDLE);
    // A restore owns the whole bank for its cycle, so port writes lose.
    assign accept = idle && !restore_req;

    cpuc_reg_bank_wr_arb #(
        .NUM_REGS     (NUM_REGS),
        .DATA_WIDTH   (DATA_WIDTH),
        .NUM_WR_PORTS (NUM_WR_PORTS),
        .AW           (AW)
    ) u_wr_arb (
        .accept    (accept),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .collision (wr_collision_d),
        .dropped   (wr_dropped_d)
    );

    always_comb begin
        regs_d   = regs_q;
        shadow_d = shadow_q;
        if (!idle) begin
            regs_d[cnt_q] = '0;
        end else if (restore_req) begin
            regs_d = shadow_q;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (reg_we[r]) begin
                    regs_d[r] = reg_wdata[r];
                end
            end
            if (snap_req) begin
                shadow_d = regs_q;
            end
        end
    end

    // Reads see the next-state bank, giving write-through bypass.
    always_comb begin
        rd_data_d = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            if (32'(bus.rd_addr[p]) < NUM_REGS) begin
                rd_data_d[p] = regs_d[bus.rd_addr[p]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r]   <= '0;
                shadow_q[r] <= '0;
            end
            rd_data_q      <= '0;
            wr_collision_q <= 1'b0;
            wr_dropped_q   <= 1'b0;
        end else begin
            regs_q         <= regs_d;
            shadow_q       <= shadow_d;
            rd_data_q      <= rd_data_d;
            wr_collision_q <= wr_collision_d;
            wr_dropped_q   <= wr_dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            init_busy_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (init_req) begin
                        state_q     <= INIT;
                        cnt_q       <= '0;
                        init_busy_q <= 1'b1;
                    end
                end
                INIT: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        init_busy_q <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign init_busy    = init_busy_q;
    assign init_done    = init_done_q;
    assign wr_collision = wr_collision_q;
    assign wr_dropped   = wr_dropped_q;
    assign bus.rd_data  = rd_data_q;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_out
        assign reg_outputs[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
    end

endmodule

// File: tb/tb_cpuc_reg_bank.sv
// Directed bench for cpuc_reg_bank: vector table plus multi-cycle sequences.
module tb_cpuc_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          init_req;
    logic          snap_req;
    logic          restore_req;
    logic          init_busy;
    logic          init_done;
    logic          wr_collision;
    logic          wr_dropped;
    logic [1023:0] reg_outputs;

    logic          s_init_req;
    logic          s_snap_req;
    logic          s_restore_req;
    logic          s_init_busy;
    logic          s_init_done;
    logic          s_wr_collision;
    logic          s_wr_dropped;
    logic [639:0]  s_reg_outputs;

    cpuc_reg_bank_if #(
        .NUM_WR_PORTS(2), .NUM_RD_PORTS(2), .AW(5), .DATA_WIDTH(32)
    ) bus ();

    cpuc_reg_bank_if #(
        .NUM_WR_PORTS(2), .NUM_RD_PORTS(2), .AW(5), .DATA_WIDTH(32)
    ) sbus ();

    cpuc_reg_bank dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .init_req     (init_req),
        .init_busy    (init_busy),
        .init_done    (init_done),
        .snap_req     (snap_req),
        .restore_req  (restore_req),
        .wr_collision (wr_collision),
        .wr_dropped   (wr_dropped),
        .reg_outputs  (reg_outputs)
    );

    // 20-register bank: leaves addresses 20..31 reachable but out of range.
    cpuc_reg_bank #(.NUM_REGS(20)) sdut (
        .clk          (clk),
        .rst          (rst),
        .bus          (sbus),
        .init_req     (s_init_req),
        .init_busy    (s_init_busy),
        .init_done    (s_init_done),
        .snap_req     (s_snap_req),
        .restore_req  (s_restore_req),
        .wr_collision (s_wr_collision),
        .wr_dropped   (s_wr_dropped),
        .reg_outputs  (s_reg_outputs)
    );

    typedef struct {
        logic [1:0]  en;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_col;
        logic        e_drop;
        logic [4:0]  creg;
        logic [31:0] e_creg;
    } vec_t;

    vec_t vt [8];

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_bank(string name, logic [1023:0] act,
                            logic [1023:0] exp);
        int k;
        checks++;
        if (act !== exp) begin
            errors++;
            k = 0;
            for (int i = 31; i >= 0; i--) begin
                if (act[i*32 +: 32] !== exp[i*32 +: 32]) k = i;
            end
            $display("FAIL %s: reg %0d got %0h expected %0h", name, k,
                     act[k*32 +: 32], exp[k*32 +: 32]);
        end
    endtask

    function automatic logic [31:0] rg(int i);
        return reg_outputs[i*32 +: 32];
    endfunction

    task automatic drive_wr(logic [1:0] en, logic [4:0] a0, logic [31:0] d0,
                            logic [4:0] a1, logic [31:0] d1);
        bus.wr_en      = en;
        bus.wr_addr[0] = a0;
        bus.wr_data[0] = d0;
        bus.wr_addr[1] = a1;
        bus.wr_data[1] = d1;
    endtask

    initial begin
        logic [1023:0] exp_bank;
        int busy_cnt;
        int done_cnt;
        int done_at;

        vt[0] = '{2'b11, 5'd5, 32'h11, 5'd5, 32'h22, 5'd5, 5'd5,
                  32'h22, 32'h22, 1'b1, 1'b0, 5'd5, 32'h22};
        vt[1] = '{2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0, 5'd7, 5'd5,
                  32'hDEADBEEF, 32'h22, 1'b0, 1'b0, 5'd7, 32'hDEADBEEF};
        vt[2] = '{2'b00, 5'd7, 32'h123, 5'd7, 32'h456, 5'd7, 5'd0,
                  32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 5'd5, 32'h22};
        vt[3] = '{2'b11, 5'd1, 32'h100, 5'd2, 32'h200, 5'd1, 5'd2,
                  32'h100, 32'h200, 1'b0, 1'b0, 5'd2, 32'h200};
        vt[4] = '{2'b10, 5'd2, 32'h999, 5'd1, 32'h111, 5'd1, 5'd2,
                  32'h111, 32'h200, 1'b0, 1'b0, 5'd1, 32'h111};
        vt[5] = '{2'b11, 5'd31, 32'hFFFFFFFF, 5'd0, 32'hA5A5A5A5, 5'd31,
                  5'd0, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b0, 1'b0, 5'd31,
                  32'hFFFFFFFF};
        vt[6] = '{2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 5'd9, 5'd3,
                  32'h2, 32'h0, 1'b1, 1'b0, 5'd9, 32'h2};
        vt[7] = '{2'b01, 5'd9, 32'h3, 5'd9, 32'h9, 5'd9, 5'd9,
                  32'h3, 32'h3, 1'b0, 1'b0, 5'd9, 32'h3};

        rst           = 1'b1;
        init_req      = 1'b0;
        snap_req      = 1'b0;
        restore_req   = 1'b0;
        s_init_req    = 1'b0;
        s_snap_req    = 1'b0;
        s_restore_req = 1'b0;
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        bus.rd_addr   = '0;
        sbus.wr_en    = '0;
        sbus.wr_addr  = '0;
        sbus.wr_data  = '0;
        sbus.rd_addr  = '0;
        step();
        step();
        rst = 1'b0;

        chk_bank("reset_bank", reg_outputs, '0);
        chk("reset_rd0", bus.rd_data[0], 32'h0);
        chk("reset_rd1", bus.rd_data[1], 32'h0);
        chk1("reset_busy", init_busy, 1'b0);
        chk1("reset_done", init_done, 1'b0);
        chk1("reset_col", wr_collision, 1'b0);
        chk1("reset_drop", wr_dropped, 1'b0);
        chk_bank("reset_small_bank", 1024'(s_reg_outputs), '0);

        for (int i = 0; i < 8; i++) begin
            drive_wr(vt[i].en, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1);
            bus.rd_addr[0] = vt[i].ra0;
            bus.rd_addr[1] = vt[i].ra1;
            step();
            chk($sformatf("vec%0d_rd0", i), bus.rd_data[0], vt[i].e_rd0);
            chk($sformatf("vec%0d_rd1", i), bus.rd_data[1], vt[i].e_rd1);
            chk1($sformatf("vec%0d_col", i), wr_collision, vt[i].e_col);
            chk1($sformatf("vec%0d_drop", i), wr_dropped, vt[i].e_drop);
            chk($sformatf("vec%0d_reg", i), rg(int'(vt[i].creg)),
                vt[i].e_creg);
        end
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        // Snapshot takes the pre-write value; restore drops port writes.
        drive_wr(2'b01, 5'd3, 32'hA, 5'd0, 32'h0);
        step();
        chk("snap_pre_r3", rg(3), 32'hA);
        snap_req = 1'b1;
        drive_wr(2'b01, 5'd3, 32'hB, 5'd0, 32'h0);
        step();
        snap_req = 1'b0;
        chk("snap_write_r3", rg(3), 32'hB);
        restore_req = 1'b1;
        drive_wr(2'b01, 5'd4, 32'h44, 5'd0, 32'h0);
        bus.rd_addr[0] = 5'd3;
        bus.rd_addr[1] = 5'd4;
        step();
        restore_req = 1'b0;
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("restore_r3", rg(3), 32'hA);
        chk("restore_r4", rg(4), 32'h0);
        chk("restore_r5", rg(5), 32'h22);
        chk1("restore_drop", wr_dropped, 1'b1);
        chk("restore_rd0", bus.rd_data[0], 32'hA);

        drive_wr(2'b01, 5'd3, 32'hC, 5'd0, 32'h0);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        snap_req    = 1'b1;
        restore_req = 1'b1;
        step();
        snap_req    = 1'b0;
        restore_req = 1'b0;
        chk("snap_restore_r3", rg(3), 32'hA);
        drive_wr(2'b01, 5'd3, 32'hD, 5'd0, 32'h0);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        restore_req = 1'b1;
        step();
        restore_req = 1'b0;
        chk("shadow_kept_r3", rg(3), 32'hA);

        exp_bank = '0;
        for (int i = 0; i < 16; i++) begin
            drive_wr(2'b11, 5'(2*i), 32'(2*i + 1) * 32'h01010101,
                     5'(2*i + 1), 32'(2*i + 2) * 32'h01010101);
            step();
        end
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            exp_bank[i*32 +: 32] = 32'(i + 1) * 32'h01010101;
        end
        chk_bank("fill_bank", reg_outputs, exp_bank);

        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        init_req = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 0) begin
                init_req = 1'b0;
                snap_req = 1'b1;
                drive_wr(2'b01, 5'd3, 32'h77, 5'd0, 32'h0);
            end
            if (i == 1) begin
                snap_req = 1'b0;
                drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
                chk1("init_wr_dropped", wr_dropped, 1'b1);
            end
            if (i == 5) init_req = 1'b1;
            if (i == 6) init_req = 1'b0;
            if (init_busy) busy_cnt++;
            if (init_done) begin
                done_cnt++;
                done_at = i;
            end
        end
        chk("init_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("init_done_count", 32'(done_cnt), 32'd1);
        chk("init_done_cycle", 32'(done_at), 32'd32);
        chk_bank("init_cleared", reg_outputs, '0);
        restore_req = 1'b1;
        step();
        restore_req = 1'b0;
        chk("init_no_snap_r3", rg(3), 32'hA);
        chk("init_restore_r7", rg(7), 32'hDEADBEEF);

        // Reset in the middle of a clear sequence.
        drive_wr(2'b01, 5'd20, 32'h20, 5'd0, 32'h0);
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        bus.rd_addr[0] = 5'd20;
        bus.rd_addr[1] = 5'd7;
        init_req = 1'b1;
        step();
        init_req = 1'b0;
        for (int i = 1; i < 10; i++) step();
        chk1("mid_init_busy", init_busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk1("abort_busy", init_busy, 1'b0);
        chk1("abort_done", init_done, 1'b0);
        chk1("abort_drop", wr_dropped, 1'b0);
        chk_bank("abort_bank", reg_outputs, '0);
        chk("abort_rd0", bus.rd_data[0], 32'h0);
        chk("abort_rd1", bus.rd_data[1], 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (init_done) done_cnt++;
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        drive_wr(2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
        bus.rd_addr[0] = 5'd6;
        step();
        drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("abort_next_wr", rg(6), 32'h66);
        chk("abort_next_rd", bus.rd_data[0], 32'h66);

        // Out-of-range write and read on the 20-register bank.
        sbus.wr_en      = 2'b01;
        sbus.wr_addr[0] = 5'd2;
        sbus.wr_data[0] = 32'h5;
        step();
        sbus.wr_addr[0] = 5'd25;
        sbus.wr_data[0] = 32'hBAD;
        sbus.rd_addr[0] = 5'd25;
        sbus.rd_addr[1] = 5'd2;
        step();
        sbus.wr_en = 2'b00;
        exp_bank = '0;
        exp_bank[2*32 +: 32] = 32'h5;
        chk1("oor_drop", s_wr_dropped, 1'b1);
        chk_bank("oor_bank", 1024'(s_reg_outputs), exp_bank);
        chk("oor_rd", sbus.rd_data[0], 32'h0);
        chk("oor_rd_in", sbus.rd_data[1], 32'h5);
        sbus.wr_en      = 2'b10;
        sbus.wr_addr[1] = 5'd19;
        sbus.wr_data[1] = 32'h19;
        step();
        sbus.wr_en = 2'b00;
        exp_bank[19*32 +: 32] = 32'h19;
        chk1("last_reg_drop", s_wr_dropped, 1'b0);
        chk_bank("last_reg_bank", 1024'(s_reg_outputs), exp_bank);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
